// File: rtl/uart_echo_fifo.sv
// ---------------------------------------------------------------------------
// uart_echo_fifo
//
// Buffered echo stage between the UART receiver and the UART transmitter.
// Good received bytes are queued in a circular FIFO and drained into the
// transmitter one at a time through the tx_start / tx_data_out / tx_busy
// handshake. Bytes with a parity error are discarded, and bytes arriving
// while the FIFO is full are dropped. Both events are counted so they can
// be watched on an ILA.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   BUSY_WAIT  cycles to wait for tx_busy to rise after tx_start before the
//              byte is assumed sent (>= 1)
//
// Ports
//   clk              system clock
//   rst              asynchronous active-high reset
//   rx_data_in       received byte, qualified by rx_ready
//   rx_ready         one-cycle strobe, a byte was received
//   rx_parity_error  qualifies rx_ready, 1 = byte is bad
//   tx_busy          transmitter is busy
//   clear            synchronous flush of FIFO, flags and counters
//   tx_start         one-cycle transmit strobe
//   tx_data_out      byte to transmit, held until the next tx_start
//   fifo_level       current occupancy, 0..DEPTH
//   overflow         sticky, a good byte was dropped because of a full FIFO
//   drop_count       bytes dropped on full, saturates at 255
//   perr_count       bytes discarded for parity, saturates at 255
// ---------------------------------------------------------------------------
module uart_echo_fifo #(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data_in,
  input  logic                     rx_ready,
  input  logic                     rx_parity_error,
  input  logic                     tx_busy,
  input  logic                     clear,
  output logic                     tx_start,
  output logic [7:0]               tx_data_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [7:0]               perr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(BUSY_WAIT - 1);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [7:0]    CNT_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] wait_cnt;
  state_t        state;

  logic full;
  logic empty;
  logic rx_good;
  logic push;
  logic pop;

  // Full/empty come from the registered level, so a pop in the same cycle
  // never makes room for a write arriving in that cycle. clear suppresses
  // both push and pop.
  always_comb begin
    full    = (fifo_level == FULL_LEVEL);
    empty   = (fifo_level == '0);
    rx_good = rx_ready && !rx_parity_error;
    push    = rx_good && !full && !clear;
    pop     = (state == IDLE) && !empty && !tx_busy && !clear;
  end

  // Storage array. Contents are don't-care after reset, so it carries no
  // reset and can map onto plain registers or distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_in;
    end
  end

  // Pointers wrap naturally at DEPTH; the level counter is kept separately
  // so full and empty are unambiguous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LEVEL_ONE;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LEVEL_ONE;
      end
    end
  end

  // Debug flags and saturating counters for dropped and bad bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      perr_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      perr_count <= '0;
    end else if (rx_ready) begin
      if (rx_parity_error) begin
        if (perr_count != CNT_MAX) begin
          perr_count <= perr_count + 8'd1;
        end
      end else if (full) begin
        overflow <= 1'b1;
        if (drop_count != CNT_MAX) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // Drain FSM. A byte is handed to the transmitter from IDLE, then we wait
  // for tx_busy to rise (or give up after BUSY_WAIT cycles for transmitters
  // that never show busy) and for it to fall again before the next byte.
  // tx_data_out is only loaded on a pop, so clear leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data_out <= '0;
      wait_cnt    <= '0;
    end else if (clear) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_data_out <= mem[rd_ptr];
            tx_start    <= 1'b1;
            wait_cnt    <= '0;
            state       <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          tx_start <= 1'b0;
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_fifo
//
// Self-checking bench for uart_echo_fifo. The reference model is a byte
// queue of what should still be transmitted, plus plain counters for drops,
// parity discards and the overflow flag. A small transmitter model goes
// busy for tx_len cycles after each tx_start (0 = never busy), and can be
// forced busy with hold_busy. Inputs are driven just after the falling edge
// and outputs are observed there, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_uart_echo_fifo;

  localparam int DEPTH     = 16;
  localparam int BUSY_WAIT = 4;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data_in;
  logic       rx_ready;
  logic       rx_parity_error;
  logic       tx_busy;
  logic       clear;
  logic       tx_start;
  logic [7:0] tx_data_out;
  logic [4:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;
  logic [7:0] perr_count;

  // Transmitter model and bookkeeping
  logic       hold_busy;
  int         busy_cnt;
  int         tx_len;
  logic       busy_q;
  logic       start_q;
  int         cyc;
  int         start_count;
  int         start_stamps[$];

  // Reference model
  logic [7:0] exp_q[$];
  int         m_drop;
  int         m_perr;
  logic       m_ovf;

  int compared;
  int failed;

  uart_echo_fifo #(
    .DEPTH(DEPTH),
    .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data_in(rx_data_in),
    .rx_ready(rx_ready),
    .rx_parity_error(rx_parity_error),
    .tx_busy(tx_busy),
    .clear(clear),
    .tx_start(tx_start),
    .tx_data_out(tx_data_out),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .drop_count(drop_count),
    .perr_count(perr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = hold_busy | (busy_cnt != 0);

  // Watches every transmission: data must be the oldest byte the model
  // still owes, the transmitter must have been idle when it was launched,
  // and tx_start must be a single-cycle pulse.
  task automatic monitor();
    forever begin
      @(posedge clk);
      cyc++;
      busy_q = tx_busy;
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        start_q  = 1'b0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start === 1'b1) begin
          start_count++;
          start_stamps.push_back(cyc);
          compared++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("[TB] FAIL tx_unexpected: got tx_start data %02h, want no transmission", tx_data_out);
          end else begin
            if (tx_data_out !== exp_q[0]) begin
              failed++;
              $display("[TB] FAIL tx_data: got %02h, want %02h", tx_data_out, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
          compared++;
          if (busy_q !== 1'b0) begin
            failed++;
            $display("[TB] FAIL tx_while_busy: got tx_start with tx_busy=%b, want tx_busy=0", busy_q);
          end
          compared++;
          if (start_q !== 1'b0) begin
            failed++;
            $display("[TB] FAIL tx_start_width: got 2+ cycle pulse, want 1 cycle");
          end
          if (tx_len > 0) busy_cnt = tx_len;
        end
        start_q = tx_start;
      end
    end
  endtask

  // Drives one cycle of inputs, updates the model with what the DUT should
  // do at the coming rising edge, then advances to just after the next
  // falling edge.
  task automatic apply_stimulus(input logic rdy, input logic [7:0] d,
                                input logic perr, input logic clr);
    rx_ready        = rdy;
    rx_data_in      = d;
    rx_parity_error = perr;
    clear           = clr;
    if (clr) begin
      exp_q.delete();
      m_drop = 0;
      m_perr = 0;
      m_ovf  = 1'b0;
    end else if (rdy) begin
      if (perr) begin
        if (m_perr < 255) m_perr++;
      end else if (exp_q.size() == DEPTH) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        exp_q.push_back(d);
      end
    end
    @(negedge clk);
    #1;
    rx_ready        = 1'b0;
    rx_parity_error = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0) && n < budget) begin
      idle(1);
      n++;
    end
    compared++;
    if (n >= budget) begin
      failed++;
      $display("[TB] FAIL drain_%s: got %0d bytes still owed, want 0", name, exp_q.size());
    end
    idle(BUSY_WAIT + 3);
  endtask

  task automatic test_reset();
    compared++;
    if (tx_start !== 1'b0) begin failed++; $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); end
    compared++;
    if (tx_data_out !== 8'h00) begin failed++; $display("[TB] FAIL reset_tx_data: got %02h want 00", tx_data_out); end
    compared++;
    if (fifo_level !== 5'd0) begin failed++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
    compared++;
    if (overflow !== 1'b0) begin failed++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    compared++;
    if (drop_count !== 8'd0) begin failed++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_count); end
    compared++;
    if (perr_count !== 8'd0) begin failed++; $display("[TB] FAIL reset_perr: got %0d want 0", perr_count); end
  endtask

  task automatic test_single_byte();
    tx_len    = 20;
    hold_busy = 1'b0;
    apply_stimulus(1'b1, 8'h41, 1'b0, 1'b0);
    compared++;
    if (fifo_level !== 5'd1) begin failed++; $display("[TB] FAIL single_level1: got %0d want 1", fifo_level); end
    idle(1);
    compared++;
    if (tx_start !== 1'b1) begin failed++; $display("[TB] FAIL single_start: got %b want 1", tx_start); end
    compared++;
    if (tx_data_out !== 8'h41) begin failed++; $display("[TB] FAIL single_data: got %02h want 41", tx_data_out); end
    compared++;
    if (fifo_level !== 5'd0) begin failed++; $display("[TB] FAIL single_level0: got %0d want 0", fifo_level); end
    wait_drain("single", 200);
  endtask

  task automatic test_burst_under_busy();
    int base;
    tx_len    = 20;
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    compared++;
    if (fifo_level !== 5'd5) begin failed++; $display("[TB] FAIL burst_level: got %0d want 5", fifo_level); end
    base      = start_count;
    hold_busy = 1'b0;
    wait_drain("burst", 400);
    compared++;
    if (start_count - base != 5) begin failed++; $display("[TB] FAIL burst_starts: got %0d want 5", start_count - base); end
  endtask

  task automatic test_overflow();
    int base;
    tx_len    = 4;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    compared++;
    if (fifo_level !== 5'd16) begin failed++; $display("[TB] FAIL ovf_level: got %0d want 16", fifo_level); end
    compared++;
    if (overflow !== 1'b1) begin failed++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    compared++;
    if (drop_count !== 8'd3) begin failed++; $display("[TB] FAIL ovf_drop: got %0d want 3", drop_count); end
    base      = start_count;
    hold_busy = 1'b0;
    wait_drain("overflow", 1000);
    compared++;
    if (start_count - base != DEPTH) begin failed++; $display("[TB] FAIL ovf_starts: got %0d want %0d", start_count - base, DEPTH); end
  endtask

  task automatic test_parity_discard();
    int base;
    tx_len = 6;
    base   = start_count;
    apply_stimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
    wait_drain("parity", 200);
    compared++;
    if (perr_count !== 8'd1) begin failed++; $display("[TB] FAIL perr_count: got %0d want 1", perr_count); end
    compared++;
    if (start_count - base != 1) begin failed++; $display("[TB] FAIL perr_starts: got %0d want 1", start_count - base); end
  endtask

  task automatic test_pointer_wrap();
    int base;
    int n;
    tx_len = 3;
    base   = start_count;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (exp_q.size() >= 3 && n < 100) begin
        idle(1);
        n++;
      end
      apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      compared++;
      if (int'(fifo_level) != exp_q.size() || fifo_level > 5'd3) begin
        failed++;
        $display("[TB] FAIL wrap_level: got %0d want %0d (max 3)", fifo_level, exp_q.size());
      end
    end
    wait_drain("wrap", 400);
    compared++;
    if (fifo_level !== 5'd0) begin failed++; $display("[TB] FAIL wrap_final_level: got %0d want 0", fifo_level); end
    compared++;
    if (start_count - base != 40) begin failed++; $display("[TB] FAIL wrap_starts: got %0d want 40", start_count - base); end
  endtask

  task automatic test_busy_timeout();
    int first;
    tx_len = 0;
    first  = start_stamps.size();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    wait_drain("timeout", 200);
    compared++;
    if (start_stamps.size() - first != 3) begin
      failed++;
      $display("[TB] FAIL timeout_starts: got %0d want 3", start_stamps.size() - first);
    end else begin
      for (int k = first + 1; k < first + 3; k++) begin
        compared++;
        if (start_stamps[k] - start_stamps[k-1] != BUSY_WAIT + 1) begin
          failed++;
          $display("[TB] FAIL timeout_gap: got %0d want %0d", start_stamps[k] - start_stamps[k-1], BUSY_WAIT + 1);
        end
      end
    end
  endtask

  task automatic test_saturation_and_clear();
    logic [7:0] held;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 260; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) apply_stimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
    compared++;
    if (drop_count !== 8'd255) begin failed++; $display("[TB] FAIL sat_drop: got %0d want 255", drop_count); end
    compared++;
    if (perr_count !== 8'd255) begin failed++; $display("[TB] FAIL sat_perr: got %0d want 255", perr_count); end
    held = tx_data_out;
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1);
    compared++;
    if (fifo_level !== 5'd0) begin failed++; $display("[TB] FAIL clr_level: got %0d want 0", fifo_level); end
    compared++;
    if (drop_count !== 8'd0 || perr_count !== 8'd0 || overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL clr_counters: got drop %0d perr %0d ovf %b, want 0 0 0", drop_count, perr_count, overflow);
    end
    compared++;
    if (tx_data_out !== held) begin failed++; $display("[TB] FAIL clr_tx_hold: got %02h want %02h", tx_data_out, held); end
    hold_busy = 1'b0;
    idle(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) hold_busy = ~hold_busy;
      tx_len = $urandom_range(0, 8);
      apply_stimulus(($urandom_range(0, 2) == 0), 8'($urandom),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 96) == 0));
      compared++;
      if (int'(fifo_level) != exp_q.size()) begin
        failed++;
        $display("[TB] FAIL rand_level: got %0d want %0d", fifo_level, exp_q.size());
      end
      compared++;
      if (int'(drop_count) != m_drop || int'(perr_count) != m_perr || overflow !== m_ovf) begin
        failed++;
        $display("[TB] FAIL rand_flags: got drop %0d perr %0d ovf %b, want %0d %0d %b",
                 drop_count, perr_count, overflow, m_drop, m_perr, m_ovf);
      end
    end
    hold_busy = 1'b0;
    wait_drain("random", 2000);
  endtask

  // Fill to 7 queued bytes with the FSM parked in WAIT_DONE behind a long
  // transmission; the first byte is forced nonzero so a reset is visible.
  task automatic fill_seven();
    tx_len    = 60;
    hold_busy = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'($urandom) | 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    int base;
    fill_seven();
    compared++;
    if (fifo_level !== 5'd7) begin failed++; $display("[TB] FAIL clr7_level_before: got %0d want 7", fifo_level); end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if (fifo_level !== 5'd0 || drop_count !== 8'd0 || perr_count !== 8'd0) begin
      failed++;
      $display("[TB] FAIL clr7_after: got level %0d drop %0d perr %0d, want 0 0 0", fifo_level, drop_count, perr_count);
    end
    base = start_count;
    idle(80);
    compared++;
    if (start_count != base) begin failed++; $display("[TB] FAIL clr7_no_start: got %0d starts want 0", start_count - base); end
  endtask

  task automatic test_async_reset();
    int base;
    fill_seven();
    compared++;
    if (fifo_level !== 5'd7) begin failed++; $display("[TB] FAIL rst7_level_before: got %0d want 7", fifo_level); end
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_drop = 0;
    m_perr = 0;
    m_ovf  = 1'b0;
    compared++;
    if (tx_start !== 1'b0 || tx_data_out !== 8'h00 || fifo_level !== 5'd0 ||
        overflow !== 1'b0 || drop_count !== 8'd0 || perr_count !== 8'd0) begin
      failed++;
      $display("[TB] FAIL rst_async: got start %b data %02h level %0d ovf %b drop %0d perr %0d, want all 0",
               tx_start, tx_data_out, fifo_level, overflow, drop_count, perr_count);
    end
    @(negedge clk);
    #1;
    rst  = 1'b0;
    base = start_count;
    idle(20);
    compared++;
    if (start_count != base || fifo_level !== 5'd0) begin
      failed++;
      $display("[TB] FAIL rst_quiet: got %0d starts level %0d, want 0 0", start_count - base, fifo_level);
    end
  endtask

  initial begin
    rst             = 1'b1;
    rx_data_in      = 8'h00;
    rx_ready        = 1'b0;
    rx_parity_error = 1'b0;
    clear           = 1'b0;
    hold_busy       = 1'b0;
    busy_cnt        = 0;
    tx_len          = 20;
    busy_q          = 1'b0;
    start_q         = 1'b0;
    cyc             = 0;
    start_count     = 0;
    m_drop          = 0;
    m_perr          = 0;
    m_ovf           = 1'b0;
    compared        = 0;
    failed          = 0;

    fork
      monitor();
      begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    @(negedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle(2);

    test_single_byte();
    test_burst_under_busy();
    test_overflow();
    test_parity_discard();
    test_pointer_wrap();
    test_busy_timeout();
    test_saturation_and_clear();
    test_random();
    test_clear();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered echo stage between the UART receiver and transmitter of `uart_interface`. It consumes received bytes (`rx_data_out`/`rx_ready`/`parity_error`) and stores good bytes in a circular FIFO. It drains the FIFO into the transmitter through the `tx_start`/`tx_data_in`/`tx_busy` handshake. Back-to-back input no longer overwrites a byte waiting to be sent; drops and parity errors are counted for ILA/debug.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `BUSY_WAIT`, 4: cycles to wait for `tx_busy` to rise after `tx_start` before the byte is treated as sent; minimum 1.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `rx_data_in` in 8: received byte, valid when `rx_ready`=1.
- `rx_ready` in 1: one-cycle strobe, byte received.
- `rx_parity_error` in 1: qualifies `rx_ready`; 1 means the byte is bad.
- `tx_busy` in 1: transmitter busy.
- `clear` in 1: synchronous; flushes FIFO, clears flags and counters.
- `tx_start` out 1: one-cycle transmit strobe.
- `tx_data_out` out 8: byte to transmit; stable from `tx_start` until the next `tx_start`.
- `fifo_level` out log2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `drop_count` out 8: bytes dropped on full; saturates at 255.
- `perr_count` out 8: bytes discarded for parity; saturates at 255.

## Operation
- Storage:
  - DEPTH×8 register array.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is held in a separate counter, 0..DEPTH; full = level==DEPTH, empty = level==0.
- Write, evaluated on a `rx_ready`=1 cycle:
  - `rx_parity_error`=1: byte discarded; `perr_count`+1. FIFO and `overflow` untouched.
  - Else, not full: array[wr_ptr]←byte; wr_ptr+1; level+1.
  - Else, full: byte dropped; `overflow`←1; `drop_count`+1.
  - Full is judged on the registered level at the start of the cycle. A write arriving in the same cycle as a pop from a full FIFO is still dropped.
- Drain FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE → WAIT_BUSY when !empty && !`tx_busy`. On that edge: `tx_data_out`←array[rd_ptr]; rd_ptr+1; level−1; `tx_start`←1.
  - WAIT_BUSY: `tx_start`←0.
    - `tx_busy`=1 → WAIT_DONE.
    - Else wait counter+1; on reaching BUSY_WAIT → IDLE.
  - WAIT_DONE → IDLE when `tx_busy`=0.
- Simultaneous push and pop, not full, no parity error: level unchanged, both pointers advance.
- `clear` takes priority over push and pop in the same cycle:
  - Pointers, level, counters, `overflow` → 0; FSM → IDLE; `tx_start`→0.
  - `tx_data_out` holds its value.
  - A transmission already in progress in `uart_interface` is not aborted.
- Counters saturate at 255 and never wrap.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data_out`=0x00, `fifo_level`=0, `overflow`=0, `drop_count`=0, `perr_count`=0.
  - FSM=IDLE; pointers=0.
  - Array contents are don't-care.
- Reset asserted mid-transfer returns everything to reset values immediately, regardless of `clk`.
- All outputs are registered.
- Write latency:
  - `rx_ready` at edge N is visible in `fifo_level` after edge N.
  - Earliest `tx_start` is after edge N+1, i.e. 2 cycles from the `rx_ready` sample into an empty FIFO with `tx_busy`=0.
- `tx_start` is high exactly one cycle. `tx_data_out` is valid in the same cycle and held until the next `tx_start`.
- Minimum `tx_start` spacing is 3 cycles.
- If `tx_busy` never rises (e.g. a 1-cycle-latency transmitter that went busy and idle in time, or no transmitter), the FSM returns to IDLE after BUSY_WAIT cycles in WAIT_BUSY.
- `fifo_level` never exceeds DEPTH and never underflows; no pop when empty.

## Test plan
- Single byte: `rx_data_in`=0x41 with `rx_ready` pulse, `tx_busy`=0 → `fifo_level`=1 next cycle; `tx_start` one cycle later with `tx_data_out`=0x41; `fifo_level`=0.
- Burst under busy: hold `tx_busy`=1; push 0x01..0x05 → `fifo_level`=5. Release, modelling each transmission as busy for 20 cycles → `tx_start` ×5 with data 0x01..0x05 in order, each only after `tx_busy` falls.
- Overflow: `tx_busy`=1; push DEPTH+3 bytes → `fifo_level`=16, `overflow`=1, `drop_count`=3. Drain → first 16 bytes out in order.
- Parity discard: push 0xAA with `rx_parity_error`=1, then 0x55 clean → `perr_count`=1; only 0x55 transmitted.
- Pointer wrap: 40 bytes through with the FIFO never exceeding 3 entries → output sequence matches input; `fifo_level` returns to 0.
- `clear`/reset: with `fifo_level`=7 and FSM in WAIT_DONE:
  - Pulse `clear` → `fifo_level`=0, counters 0, no further `tx_start`.
  - Repeat with async `rst` mid-cycle → all outputs at reset values before the next edge.
